// File: rtl/sched_pkg.sv
// Shared encodings and constants for the pipeline scheduler / interrupt controller.
// Decode request types, FSM states, interrupt identifiers and the handler vector live here.
package sched_pkg;

    localparam logic [15:0] INT_VECTOR    = 16'h0008;
    localparam int          N_HW_IRQ      = 2;
    localparam int          IRQ_IDX_W     = (N_HW_IRQ > 1) ? $clog2(N_HW_IRQ) : 1;

    localparam logic [3:0]  INT_ID_ERET   = 4'hF;
    localparam logic [7:0]  CAUSE_HW_BASE = 8'h10;

    localparam logic [3:0]  SCHED_CONTINUE     = 4'h0;
    localparam logic [3:0]  SCHED_PAUSE_FOR_LW = 4'h1;

    typedef enum logic [1:0] {
        SCHED_ST_IDLE  = 2'b00,
        SCHED_ST_ENTRY = 2'b01
    } sched_state_e;

    // Hardware cause code for a given winning line index.
    function automatic logic [7:0] hw_cause(input logic [IRQ_IDX_W-1:0] idx);
        return CAUSE_HW_BASE + 8'(idx);
    endfunction

endpackage

// File: rtl/sched_if.sv
// Bundle between the decode stage and the scheduler: decode requests in, pipeline controls out.
// All schi_* are sampled combinationally in the current cycle; the MTIH strobe is a one-cycle pulse.
interface sched_if;
    import sched_pkg::*;

    logic                 schi_pause_request;
    logic [3:0]           schi_sched_type;
    logic                 schi_int;
    logic [3:0]           schi_int_id;
    logic                 schi_int_en_value;
    logic                 schi_int_en_write;
    logic [15:0]          schi_id_addr;
    logic                 schi_id_branch;
    logic [N_HW_IRQ-1:0]  schi_hw_irq;

    logic                 scho_stall_pc;
    logic                 scho_stall_ifid;
    logic                 scho_bubble_idex;
    logic                 scho_flush_ifid;
    logic                 scho_redirect;
    logic [15:0]          scho_redirect_pc;
    logic                 scho_int_en;
    logic [7:0]           scho_cause;
    logic [15:0]          scho_epc;
    logic [1:0]           scho_state;

    modport master (
        output schi_pause_request, schi_sched_type, schi_int, schi_int_id,
               schi_int_en_value, schi_int_en_write, schi_id_addr, schi_id_branch,
               schi_hw_irq,
        input  scho_stall_pc, scho_stall_ifid, scho_bubble_idex, scho_flush_ifid,
               scho_redirect, scho_redirect_pc, scho_int_en, scho_cause, scho_epc,
               scho_state
    );

    modport slave (
        input  schi_pause_request, schi_sched_type, schi_int, schi_int_id,
               schi_int_en_value, schi_int_en_write, schi_id_addr, schi_id_branch,
               schi_hw_irq,
        output scho_stall_pc, scho_stall_ifid, scho_bubble_idex, scho_flush_ifid,
               scho_redirect, scho_redirect_pc, scho_int_en, scho_cause, scho_epc,
               scho_state
    );

endinterface

// File: rtl/sched_irq_prio.sv
// Fixed-priority encoder over the hardware interrupt lines; line 0 is the highest priority.
module irq_prio
    import sched_pkg::*;
(
    input  logic [N_HW_IRQ-1:0]  i_irq,
    output logic                 o_any,
    output logic [IRQ_IDX_W-1:0] o_index
);

    always_comb begin
        o_any   = |i_irq;
        o_index = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N_HW_IRQ - 1; i >= 0; i--) begin
            if (i_irq[i]) begin
                o_index = IRQ_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sched.sv
// Pipeline scheduler: load-use stalls, INT/ERET sequencing and level hardware interrupts,
// plus the interrupt state (enable, cause, EPC) that MFIH/MTIH access.
module sched
    import sched_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    sched_if.slave  bus
);

    sched_state_e         r_state;
    sched_state_e         w_state_nxt;
    logic                 r_delay_slot;
    logic                 r_int_en;
    logic [7:0]           r_cause;
    logic [15:0]          r_epc;

    logic                 w_int_en_nxt;
    logic [7:0]           w_cause_nxt;
    logic [15:0]          w_epc_nxt;

    logic                 w_irq_any;
    logic [IRQ_IDX_W-1:0] w_irq_idx;

    logic                 w_idle;
    logic                 w_eret;
    logic                 w_swi;
    logic                 w_lw_stall;
    logic                 w_hw_take;

    logic                 w_stall;
    logic                 w_bubble;
    logic                 w_flush;
    logic                 w_redirect;
    logic [15:0]          w_redirect_pc;

    irq_prio u_irq_prio (
        .i_irq   (bus.schi_hw_irq),
        .o_any   (w_irq_any),
        .o_index (w_irq_idx)
    );

    // Request decode in priority order: ERET, software INT, load-use stall, hardware IRQ.
    assign w_idle     = (r_state == SCHED_ST_IDLE);
    assign w_eret     = w_idle && bus.schi_int && (bus.schi_int_id == INT_ID_ERET);
    assign w_swi      = w_idle && bus.schi_int && (bus.schi_int_id != INT_ID_ERET);
    assign w_lw_stall = w_idle && !bus.schi_int && bus.schi_pause_request &&
                        (bus.schi_sched_type == SCHED_PAUSE_FOR_LW);
    assign w_hw_take  = w_idle && !bus.schi_int && !w_lw_stall && r_int_en &&
                        !r_delay_slot && w_irq_any;

    always_comb begin
        w_state_nxt   = r_state;
        w_int_en_nxt  = r_int_en;
        w_cause_nxt   = r_cause;
        w_epc_nxt     = r_epc;
        w_stall       = 1'b0;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = INT_VECTOR;

        case (r_state)
            SCHED_ST_IDLE: begin
                if (w_eret) begin
                    w_redirect    = 1'b1;
                    w_redirect_pc = r_epc;
                    w_flush       = 1'b1;
                    w_int_en_nxt  = 1'b1;
                    w_state_nxt   = SCHED_ST_ENTRY;
                end else if (w_swi) begin
                    w_redirect    = 1'b1;
                    w_flush       = 1'b1;
                    w_epc_nxt     = bus.schi_id_addr + 16'd1;
                    w_cause_nxt   = {4'h0, bus.schi_int_id};
                    w_int_en_nxt  = 1'b0;
                    w_state_nxt   = SCHED_ST_ENTRY;
                end else if (w_lw_stall) begin
                    w_stall       = 1'b1;
                    w_bubble      = 1'b1;
                end else if (w_hw_take) begin
                    // The decode instruction is squashed and resumes after ERET.
                    w_redirect    = 1'b1;
                    w_flush       = 1'b1;
                    w_bubble      = 1'b1;
                    w_epc_nxt     = bus.schi_id_addr;
                    w_cause_nxt   = hw_cause(w_irq_idx);
                    w_int_en_nxt  = 1'b0;
                    w_state_nxt   = SCHED_ST_ENTRY;
                end

                if (!w_eret && !w_swi && !w_hw_take && bus.schi_int_en_write) begin
                    w_int_en_nxt  = bus.schi_int_en_value;
                end
            end
            SCHED_ST_ENTRY: begin
                w_flush     = 1'b1;
                w_bubble    = 1'b1;
                w_state_nxt = SCHED_ST_IDLE;
            end
            default: begin
                w_state_nxt = SCHED_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SCHED_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_delay_slot <= 1'b0;
            r_int_en     <= 1'b0;
            r_cause      <= 8'h00;
            r_epc        <= 16'h0000;
        end else begin
            r_delay_slot <= bus.schi_id_branch;
            r_int_en     <= w_int_en_nxt;
            r_cause      <= w_cause_nxt;
            r_epc        <= w_epc_nxt;
        end
    end

    // Controls are forced quiet while reset is held so nothing leaks into the pipeline.
    assign bus.scho_stall_pc    = rst && w_stall;
    assign bus.scho_stall_ifid  = rst && w_stall;
    assign bus.scho_bubble_idex = rst && w_bubble;
    assign bus.scho_flush_ifid  = rst && w_flush;
    assign bus.scho_redirect    = rst && w_redirect;
    assign bus.scho_redirect_pc = rst ? w_redirect_pc : 16'h0000;
    assign bus.scho_int_en      = r_int_en;
    assign bus.scho_cause       = r_cause;
    assign bus.scho_epc         = r_epc;
    assign bus.scho_state       = r_state;

endmodule
